pam4_frame_gen: RTL and testbench

Multi-channel PAM4 framed test-pattern generator that replaces the single-lane generator in the transmit datapath. On request it emits frames on NUM_CH parallel symbol lanes, for example the R/G/B optical channels. Each frame is an alternating max/zero header, then PAYLOAD_LEN PRBS symbols per lane, then an optional idle gap. It runs single-shot or back-to-back in continuous mode, and reports frame boundaries and a frame count for the link-level checker.

---
 rtl/pam4_frame_gen.sv | 149 ++++++++++++++
 tb/tb_pam4_frame_gen.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pam4_frame_gen.sv
// Multi-lane PAM4 framed test-pattern generator: alternating max/zero header,
// per-lane PRBS payload and optional idle gap, in single-shot or continuous mode.
module pam4_frame_gen #(
    parameter int NUM_CH      = 3,
    parameter int SYM_BITS    = 2,
    parameter int HEAD_LEN    = 6,
    parameter int PAYLOAD_LEN = 1024,
    parameter int GAP_LEN     = 4,
    parameter int POLY_LENGTH = 9,
    parameter int POLY_TAP    = 5,
    parameter int INV_PATTERN = 1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         send_enable,
    input  logic                         send_stop,
    input  logic                         cfg_continuous,
    output logic [NUM_CH*SYM_BITS-1:0]   data_out,
    output logic                         data_valid,
    output logic                         frame_start,
    output logic                         frame_done,
    output logic                         busy,
    output logic [15:0]                  frame_cnt
);

    localparam int DW      = NUM_CH * SYM_BITS;
    localparam int MAX_HP  = (HEAD_LEN > PAYLOAD_LEN) ? HEAD_LEN : PAYLOAD_LEN;
    localparam int MAX_LEN = (MAX_HP > GAP_LEN) ? MAX_HP : GAP_LEN;
    localparam int CNT_W   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    localparam logic [CNT_W-1:0] HEAD_LAST = CNT_W'(HEAD_LEN - 1);
    localparam logic [CNT_W-1:0] PAY_LAST  = CNT_W'(PAYLOAD_LEN - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
    localparam logic             INV       = (INV_PATTERN != 0);

    typedef enum logic [1:0] {IDLE, HEAD, PAYLOAD, GAP} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             stop_pending, stop_next;
    logic [DW-1:0]    data_next;
    logic             done_next;

    logic [POLY_LENGTH-1:0] lfsr     [NUM_CH];
    logic [POLY_LENGTH-1:0] lfsr_adv [NUM_CH];
    logic [SYM_BITS-1:0]    prbs_sym [NUM_CH];

    // One payload symbol: SYM_BITS Fibonacci steps, first generated bit lands in the MSB.
    function automatic logic [SYM_BITS+POLY_LENGTH-1:0] prbs_step(input logic [POLY_LENGTH-1:0] s_in);
        logic [POLY_LENGTH-1:0] s;
        logic [SYM_BITS-1:0]    sym;
        logic                   b;
        s   = s_in;
        sym = '0;
        for (int k = 0; k < SYM_BITS; k++) begin
            b                    = s[POLY_LENGTH-1] ^ s[POLY_TAP-1];
            s                    = {s[POLY_LENGTH-2:0], b};
            sym[SYM_BITS-1-k]    = b ^ INV;
        end
        return {sym, s};
    endfunction

    always_comb begin
        for (int c = 0; c < NUM_CH; c++) begin
            {prbs_sym[c], lfsr_adv[c]} = prbs_step(lfsr[c]);
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        cnt_next   = cnt + CNT_W'(1);
        stop_next  = stop_pending | (send_stop && state != IDLE);
        unique case (state)
            IDLE: begin
                cnt_next = '0;
                if (send_enable) state_next = HEAD;
            end
            HEAD: begin
                if (cnt == HEAD_LAST) begin
                    state_next = PAYLOAD;
                    cnt_next   = '0;
                end
            end
            PAYLOAD: begin
                if (cnt == PAY_LAST) begin
                    cnt_next = '0;
                    // A stop arriving on the last payload symbol still ends the run here.
                    if (cfg_continuous && !stop_next)
                        state_next = (GAP_LEN == 0) ? HEAD : GAP;
                    else
                        state_next = IDLE;
                end
            end
            GAP: begin
                if (cnt == GAP_LAST) begin
                    state_next = HEAD;
                    cnt_next   = '0;
                end
            end
            default: state_next = IDLE;
        endcase
        if (state_next == IDLE) stop_next = 1'b0;

        data_next = '0;
        if (state_next == HEAD && !cnt_next[0]) begin
            data_next = '1;
        end else if (state_next == PAYLOAD) begin
            for (int c = 0; c < NUM_CH; c++) data_next[c*SYM_BITS +: SYM_BITS] = prbs_sym[c];
        end
        done_next = (state_next == PAYLOAD) && (cnt_next == PAY_LAST);
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            stop_pending <= 1'b0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_start  <= 1'b0;
            frame_done   <= 1'b0;
            busy         <= 1'b0;
            frame_cnt    <= '0;
        end else begin
            state        <= state_next;
            cnt          <= cnt_next;
            stop_pending <= stop_next;
            data_out     <= data_next;
            data_valid   <= (state_next != IDLE);
            frame_start  <= (state_next == HEAD) && (cnt_next == '0);
            frame_done   <= done_next;
            busy         <= (state_next != IDLE);
            frame_cnt    <= frame_cnt + 16'(done_next);
        end
    end

    // NOTE: the LFSRs need no reset; they are reseeded on every header cycle before any payload uses them.
    always_ff @(posedge clk) begin
        for (int c = 0; c < NUM_CH; c++) begin
            if (state_next == HEAD)
                lfsr[c] <= {POLY_LENGTH{1'b1}} ^ POLY_LENGTH'(c);
            else if (state_next == PAYLOAD)
                lfsr[c] <= lfsr_adv[c];
        end
    end

endmodule

// File: tb/tb_pam4_frame_gen.sv
// Self-checking bench: two generator instances (gap 4 / inverted, gap 0 / plain) against a
// queue-of-expected-beats model, plus literal checks on the documented frame timeline.
module tb_pam4_frame_gen;

    localparam int NCH  = 3;
    localparam int HEAD = 6;
    localparam int PAY  = 16;
    localparam int DW   = NCH * 2;
    localparam int RING = 128;

    typedef struct packed {
        logic          v;
        logic          fs;
        logic          fd;
        logic [DW-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic send_enable = 1'b0;
    logic send_stop = 1'b0;
    logic cfg_continuous = 1'b0;

    logic [DW-1:0] dout  [2];
    logic          valid [2];
    logic          fs    [2];
    logic          fd    [2];
    logic          busy  [2];
    logic [15:0]   fcnt  [2];

    int total = 0;
    int bad   = 0;
    bit chk_on = 1'b0;

    beat_t       ring   [2][RING];
    int          hd     [2];
    int          tl     [2];
    beat_t       cur    [2];
    bit          stop_q [2];
    logic [15:0] mcnt   [2];
    logic [15:0] bias   [2];

    always #5 clk = ~clk;

    pam4_frame_gen #(.NUM_CH(NCH), .SYM_BITS(2), .HEAD_LEN(HEAD), .PAYLOAD_LEN(PAY), .GAP_LEN(4),
                     .POLY_LENGTH(9), .POLY_TAP(5), .INV_PATTERN(1)) u_dut0 (
        .clk(clk), .rst(rst), .send_enable(send_enable), .send_stop(send_stop),
        .cfg_continuous(cfg_continuous), .data_out(dout[0]), .data_valid(valid[0]),
        .frame_start(fs[0]), .frame_done(fd[0]), .busy(busy[0]), .frame_cnt(fcnt[0]));

    pam4_frame_gen #(.NUM_CH(NCH), .SYM_BITS(2), .HEAD_LEN(HEAD), .PAYLOAD_LEN(PAY), .GAP_LEN(0),
                     .POLY_LENGTH(9), .POLY_TAP(5), .INV_PATTERN(0)) u_dut1 (
        .clk(clk), .rst(rst), .send_enable(send_enable), .send_stop(send_stop),
        .cfg_continuous(cfg_continuous), .data_out(dout[1]), .data_valid(valid[1]),
        .frame_start(fs[1]), .frame_done(fd[1]), .busy(busy[1]), .frame_cnt(fcnt[1]));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Symbol j (0-based) of lane `lane`, regenerated bit by bit from the lane seed.
    function automatic logic [1:0] ref_sym(input int lane, input int j, input bit inv_p);
        int         s;
        int         b;
        logic [1:0] sym;
        s   = 511 ^ lane;
        sym = '0;
        for (int n = 0; n <= j; n++) begin
            for (int k = 0; k < 2; k++) begin
                b          = ((s >> 8) ^ (s >> 4)) & 1;
                s          = ((s << 1) | b) & 511;
                sym[1-k]   = 1'(b) ^ inv_p;
            end
        end
        return sym;
    endfunction

    task automatic push(input int i, input beat_t b);
        ring[i][tl[i] % RING] = b;
        tl[i]++;
    endtask

    task automatic push_frame(input int i);
        beat_t b;
        for (int h = 0; h < HEAD; h++) begin
            b    = '0;
            b.v  = 1'b1;
            b.fs = (h == 0);
            b.d  = (h % 2 == 0) ? '1 : '0;
            push(i, b);
        end
        for (int j = 0; j < PAY; j++) begin
            b    = '0;
            b.v  = 1'b1;
            b.fd = (j == PAY - 1);
            for (int c = 0; c < NCH; c++) b.d[c*2 +: 2] = ref_sym(c, j, (i == 0));
            push(i, b);
        end
    endtask

    task automatic push_gap(input int i);
        beat_t b;
        b   = '0;
        b.v = 1'b1;
        for (int g = 0; g < ((i == 0) ? 4 : 0); g++) push(i, b);
    endtask

    // Reference model: each beat on the wire is popped from a queue of whole frames.
    initial begin
        forever begin
            @(posedge clk);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    hd[i] = 0; tl[i] = 0; cur[i] = '0; stop_q[i] = 1'b0; mcnt[i] = '0;
                end else begin
                    if (cur[i].v) begin
                        if (send_stop) stop_q[i] = 1'b1;
                        if (cur[i].fd && cfg_continuous && !stop_q[i]) begin
                            push_gap(i);
                            push_frame(i);
                        end
                    end else if (send_enable) begin
                        push_frame(i);
                    end
                    if (hd[i] != tl[i]) begin
                        cur[i] = ring[i][hd[i] % RING];
                        hd[i]++;
                    end else begin
                        cur[i] = '0;
                    end
                    if (!cur[i].v) stop_q[i] = 1'b0;
                    if (cur[i].fd) mcnt[i] = mcnt[i] + 16'd1;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_on) begin
                for (int i = 0; i < 2; i++) begin
                    check($sformatf("dut%0d data_out", i), 32'(dout[i]), 32'(cur[i].d));
                    check($sformatf("dut%0d valid/busy/start/done", i),
                          {28'd0, valid[i], busy[i], fs[i], fd[i]},
                          {28'd0, cur[i].v, cur[i].v, cur[i].fs, cur[i].fd});
                    check($sformatf("dut%0d frame_cnt", i), 32'(fcnt[i]), 32'(16'(mcnt[i] + bias[i])));
                end
            end
        end
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((busy[0] || busy[1]) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("idle within budget", {30'd0, busy[0], busy[1]}, 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bias[0] = '0;
        bias[1] = '0;

        // Model self-pins against hand-derived PRBS symbols.
        check("model lane0 inv sym0", 32'(ref_sym(0, 0, 1'b1)), 32'd3);
        check("model lane0 inv sym1", 32'(ref_sym(0, 1, 1'b1)), 32'd3);
        check("model lane0 inv sym2", 32'(ref_sym(0, 2, 1'b1)), 32'd2);
        check("model lane0 plain sym2", 32'(ref_sym(0, 2, 1'b0)), 32'd1);
        begin
            bit d1, d2;
            d1 = 1'b0; d2 = 1'b0;
            for (int j = 0; j < PAY; j++) begin
                if (ref_sym(1, j, 1'b1) != ref_sym(0, j, 1'b1)) d1 = 1'b1;
                if (ref_sym(2, j, 1'b1) != ref_sym(0, j, 1'b1)) d2 = 1'b1;
            end
            check("model lanes 1,2 differ from lane 0", {30'd0, d1, d2}, 32'd3);
        end

        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        check("reset data_out", 32'(dout[0]), 32'd0);
        check("reset flags", {27'd0, valid[0], fs[0], fd[0], busy[0], 1'b0}, 32'd0);
        check("reset frame_cnt", 32'(fcnt[0]), 32'd0);
        rst = 1'b0;

        // Single frame: header on cycles 1..6, payload 7..22, idle from 23.
        @(negedge clk);
        send_enable = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            @(negedge clk);
            if (k == 1) begin
                send_enable = 1'b0;
                check("c1 frame_start", {31'd0, fs[0]}, 32'd1);
                check("c1 header max", 32'(dout[0]), 32'h3f);
                check("c1 busy", {31'd0, busy[0]}, 32'd1);
            end
            if (k == 2) check("c2 header zero", 32'(dout[0]), 32'd0);
            if (k == 7) check("c7 lane0 inv/plain", {28'd0, dout[0][1:0], dout[1][1:0]}, {28'd0, 2'd3, 2'd0});
            if (k == 8) check("c8 lane0 inv/plain", {28'd0, dout[0][1:0], dout[1][1:0]}, {28'd0, 2'd3, 2'd0});
            if (k == 9) check("c9 lane0 inv/plain", {28'd0, dout[0][1:0], dout[1][1:0]}, {28'd0, 2'd2, 2'd1});
            if (k == 22) begin
                check("c22 frame_done", {30'd0, fd[0], fd[1]}, 32'd3);
                check("c22 frame_cnt", 32'(fcnt[0]), 32'd1);
            end
            if (k == 23) check("c23 busy/valid low", {30'd0, busy[0], valid[0]}, 32'd0);
        end

        // Continuous mode, then a stop mid-payload with an ignored start alongside it.
        cfg_continuous = 1'b1;
        send_enable    = 1'b1;
        for (int k = 1; k <= 87; k++) begin
            @(negedge clk);
            if (k == 1) send_enable = 1'b0;
            if (k == 23) begin
                check("gap0 valid zero", {25'd0, valid[0], dout[0]}, 32'h40);
                check("nogap dut1 restart", {31'd0, fs[1]}, 32'd1);
            end
            if (k == 26) check("gap0 last", {25'd0, valid[0], dout[0]}, 32'h40);
            if (k == 27) check("frame2 start after gap", {31'd0, fs[0]}, 32'd1);
            if (k == 86) begin
                send_stop   = 1'b1;
                send_enable = 1'b1;
            end
            if (k == 87) begin
                send_stop   = 1'b0;
                send_enable = 1'b0;
            end
        end
        wait_idle(60);
        check("after stop dut0 cnt", 32'(fcnt[0]), 32'd5);
        check("after stop dut1 cnt", 32'(fcnt[1]), 32'd5);

        // Start and stop together in IDLE: the start wins, continuous running proceeds.
        @(negedge clk);
        send_enable = 1'b1;
        send_stop   = 1'b1;
        for (int k = 1; k <= 23; k++) begin
            @(negedge clk);
            send_enable = 1'b0;
            send_stop   = 1'b0;
        end
        check("start wins: gap not idle", {30'd0, valid[0], busy[0]}, 32'd3);
        cfg_continuous = 1'b0;
        wait_idle(80);

        // Reset in the middle of a payload.
        send_enable = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            send_enable = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mid reset data_out", 32'(dout[0]), 32'd0);
        check("mid reset flags", {28'd0, valid[0], fs[0], fd[0], busy[0]}, 32'd0);
        check("mid reset frame_cnt", 32'(fcnt[0]), 32'd0);
        rst = 1'b0;

        // Randomised traffic checked every cycle against the model.
        for (int n = 0; n < 2500; n++) begin
            @(negedge clk);
            send_enable = ($urandom_range(0, 7) == 0);
            send_stop   = ($urandom_range(0, 47) == 0);
            if ($urandom_range(0, 15) == 0) cfg_continuous = 1'($urandom_range(0, 1));
            rst = ($urandom_range(0, 599) == 0);
        end
        @(negedge clk);
        send_enable    = 1'b0;
        send_stop      = 1'b0;
        rst            = 1'b0;
        cfg_continuous = 1'b0;
        @(negedge clk);
        wait_idle(120);

        // Counter wrap: preload 0xFFFF, then one frame.
        @(posedge clk);
        #2;
        force u_dut0.frame_cnt = 16'hffff;
        bias[0] = 16'hffff - mcnt[0];
        @(posedge clk);
        #2;
        release u_dut0.frame_cnt;
        @(negedge clk);
        send_enable = 1'b1;
        begin
            int n;
            n = 0;
            @(negedge clk);
            send_enable = 1'b0;
            while (fd[0] !== 1'b1 && n < 40) begin
                @(negedge clk);
                n++;
            end
            check("wrap frame_done seen", {31'd0, fd[0]}, 32'd1);
            check("wrap frame_cnt", 32'(fcnt[0]), 32'd0);
        end
        wait_idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
